note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000, meaning clk cycles per sequencer tick (1 kHz at 25 MHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock (25 MHz); one clock, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin playback; a level, sampled each cycle.
REQ-005 SHALL have port stop  input  1  abort playback; a level, sampled each cycle.
REQ-006 SHALL have ports wr_en input 1, wr_addr input 3 and wr_data input 4, which write pattern step wr_addr; bit3 is rest, bits2:0 are freq code.
REQ-007 SHALL have port last_step  input  3  index of the final step; pattern length is last_step+1.
REQ-008 SHALL have ports note_len input 8 and gap_len input 8, giving note duration and gap duration in ticks.
REQ-009 SHALL have port freq_select  output  3  registered freq code for the downstream sawtooth/ADSR voice.
REQ-010 SHALL have ports note_on output 1 and note_off output 1, each a one-cycle registered pulse.
REQ-011 SHALL have ports busy output 1, step_idx output 3 and done output 1: playing flag, current step, one-cycle end-of-sequence pulse.

Function
REQ-012 SHALL hold an 8x4-bit pattern register file; a write when wr_en=1 takes effect at the next edge, is accepted in any state, and is used the next time that step is loaded.
REQ-013 SHALL implement states IDLE, ON, HOLD, OFF and GAP.
REQ-014 SHALL contain a tick divider that restarts at 0 on entry to ON and on entry to GAP, and produces a tick every TICK_DIV cycles.
REQ-015 IDLE: start=1 and stop=0 at edge k -> at cycle k+1 the block is in ON with busy=1, step_idx=0, and freq_select=pattern[0][2:0].
REQ-016 ON (cycle T0) SHALL last exactly one cycle; note_on=1 at T0 unless the step is a rest; the block then enters HOLD.
REQ-017 HOLD SHALL count max(note_len,1) ticks; OFF occupies cycle T0+max(note_len,1)*TICK_DIV, with note_off=1 in that cycle unless the step is a rest.
REQ-018 GAP: if gap_len=0, the next step's ON is the cycle after OFF; otherwise it is OFF cycle+gap_len*TICK_DIV.
REQ-019 Step advance at end of GAP: if step_idx<last_step -> step_idx+1 and ON; if step_idx>=last_step -> end-of-sequence handling per REQ-026/027.
REQ-020 A rest step SHALL keep the same timing as a note step, emit no note_on or note_off, and leave freq_select unchanged.
REQ-021 stop=1 sampled in any non-IDLE state at edge k -> at cycle k+1 state=IDLE and busy=0; note_off=1 in that cycle only if a non-rest note is sounding (ON or HOLD); done SHALL NOT pulse.
REQ-022 start and stop both 1 in IDLE -> stop wins and the block stays in IDLE; start while busy SHALL be ignored.
REQ-023 note_on and note_off SHALL never assert in the same cycle; freq_select SHALL change only in an ON cycle.

Reset
REQ-024 reset=1 at an edge -> the next cycle SHALL show state IDLE, freq_select=0, note_on=0, note_off=0, busy=0, step_idx=0, done=0, tick divider 0 and all pattern entries 0.
REQ-025 Reset mid-note SHALL emit no note_off pulse, and reset SHALL take priority over start, stop and wr_en.

Configuration
REQ-026 With macro SEQ_LOOP_EN defined, the end of the last step's GAP SHALL wrap to step_idx=0 and ON with no idle cycle, continuing until stop; done SHALL never assert.
REQ-027 Without SEQ_LOOP_EN, the end of the last step's GAP -> at the next cycle state=IDLE, busy=0 and done=1 for exactly one cycle.

Verification (TICK_DIV=4)
REQ-028 Pattern {1,2,3}, last_step=2, note_len=2, gap_len=1, start at cycle 0 -> note_on at cycles 1, 13, 25; note_off at 9, 21, 33; freq_select 1,2,3; done at 38 (no SEQ_LOOP_EN).
REQ-029 Step1=rest (8) in the REQ-028 setup -> no pulses at cycles 13 or 21, freq_select stays 1 until cycle 25, timing is unchanged.
REQ-030 stop at cycle 5 in the REQ-028 setup -> note_off=1 and busy=0 at cycle 6, done is never asserted, and later note_on edges are absent.
REQ-031 note_len=0, gap_len=0, last_step=0 -> note_on at 1, note_off at 5, done at 6; start=stop=1 in IDLE produces no activity.
REQ-032 SEQ_LOOP_EN, last_step=1, note_len=1, gap_len=1 -> step_idx sequence 0,1,0,1, note_on every 8 cycles, done stays 0; reset at cycle 10 -> all outputs 0 at cycle 11.

Source files
------------

// File: rtl/note_sequencer.sv
// Eight-step note sequencer: plays a pattern of freq codes as note_on/note_off pulses
// on a tick time base. Optional macro SEQ_LOOP_EN wraps to step 0 instead of ending.
module note_sequencer #(
    parameter int unsigned TICK_DIV = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [2:0] last_step,
    input  logic [7:0] note_len,
    input  logic [7:0] gap_len,
    output logic [2:0] freq_select,
    output logic       note_on,
    output logic       note_off,
    output logic       busy,
    output logic [2:0] step_idx,
    output logic       done
);
    typedef enum logic [2:0] {S_IDLE, S_ON, S_HOLD, S_OFF, S_GAP} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] DIV_EARLY = 16'(TICK_DIV - 2);

    state_t      state_q, state_d;
    logic [3:0]  pattern_q [8];
    logic [15:0] div_q, div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [2:0]  freq_q, freq_d;
    logic        rest_q, rest_d;
    logic        note_on_q, note_on_d;
    logic        note_off_q, note_off_d;
    logic        done_q, done_d;

    logic        tick, more_steps, load, finish;
    logic [7:0]  note_ticks;
    logic [2:0]  next_step, load_step;
    logic [3:0]  load_entry;

    assign tick       = (div_q == DIV_LAST);
    assign note_ticks = (note_len == 8'd0) ? 8'd1 : note_len;
    assign next_step  = (step_q < last_step) ? step_q + 3'd1 : 3'd0;
    assign load_step  = (state_q == S_IDLE) ? 3'd0 : next_step;
    assign load_entry = pattern_q[load_step];

`ifdef SEQ_LOOP_EN
    assign more_steps = 1'b1;
`else
    assign more_steps = (step_q < last_step);
`endif

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path can infer a latch.
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 16'd1;
        cnt_d      = cnt_q;
        step_d     = step_q;
        freq_d     = freq_q;
        rest_d     = rest_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        done_d     = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;

        if (stop && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            div_d      = '0;
            note_off_d = (state_q == S_ON || state_q == S_HOLD) && !rest_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    div_d = '0;
                    load  = start && !stop;
                end
                S_ON: state_d = S_HOLD;
                S_HOLD: begin
                    if (tick) begin
                        if (cnt_q == note_ticks - 8'd1) begin
                            state_d    = S_OFF;
                            note_off_d = !rest_q;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                S_OFF: begin
                    if (gap_len == 8'd0) begin
                        load   = more_steps;
                        finish = !more_steps;
                    end else begin
                        state_d = S_GAP;
                        div_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_GAP: begin
                    if (tick) cnt_d = cnt_q + 8'd1;
                    // The next ON lands on the final gap tick, so it launches one cycle early;
                    // the end-of-sequence exit waits for the tick itself.
                    if (cnt_q == gap_len - 8'd1) begin
                        if (more_steps && div_q == DIV_EARLY) load = 1'b1;
                        else if (!more_steps && tick)         finish = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load) begin
            state_d = S_ON;
            div_d   = '0;
            cnt_d   = '0;
            step_d  = load_step;
            rest_d  = load_entry[3];
            if (!load_entry[3]) begin
                freq_d    = load_entry[2:0];
                note_on_d = 1'b1;
            end
        end
        if (finish) begin
            state_d = S_IDLE;
            div_d   = '0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            freq_q     <= '0;
            rest_q     <= 1'b0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            done_q     <= 1'b0;
            // NOTE: the pattern is cleared on reset, which keeps it in flops rather than a RAM macro.
            for (int i = 0; i < 8; i++) pattern_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            freq_q     <= freq_d;
            rest_q     <= rest_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            done_q     <= done_d;
            if (wr_en) pattern_q[wr_addr] <= wr_data;
        end
    end

    assign freq_select = freq_q;
    assign note_on     = note_on_q;
    assign note_off    = note_off_q;
    assign busy        = (state_q != S_IDLE);
    assign step_idx    = step_q;
    assign done        = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Randomized scoreboard bench for note_sequencer (default build, TICK_DIV=4): a timeline
// model predicts every pulse, a negedge monitor pops and compares as pulses appear.
module tb_note_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, start, stop, wr_en;
    logic [2:0] wr_addr, last_step;
    logic [3:0] wr_data;
    logic [7:0] note_len, gap_len;
    logic [2:0] freq_select, step_idx;
    logic       note_on, note_off, busy, done;

    note_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_step(last_step), .note_len(note_len), .gap_len(gap_len),
        .freq_select(freq_select), .note_on(note_on), .note_off(note_off),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_ON, EV_OFF, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       freq;
        int       step;
    } ev_t;

    ev_t        sb_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         busy_lo = 1;
    int         busy_hi = 0;
    logic [3:0] mdl_pat [8];
    logic [2:0] prev_freq = '0;
    logic       prev_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic pop_cmp(input ev_kind_t k);
        ev_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d: got kind %0d, expected no pulse", cyc, k);
            return;
        end
        e = sb_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (k != EV_DONE) check("freq_select", freq_select, e.freq);
        if (k == EV_ON)   check("step_idx", step_idx, e.step);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
        check("on_off_overlap", note_on & note_off, 0);
        if (note_on)  pop_cmp(EV_ON);
        if (note_off) pop_cmp(EV_OFF);
        if (done)     pop_cmp(EV_DONE);
        if (!prev_reset && freq_select !== prev_freq) check("freq_change_without_note_on", note_on, 1);
        prev_freq  = freq_select;
        prev_reset = reset;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_all();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = mdl_pat[i];
            next_cycle();
        end
        wr_en = 1'b0;
    endtask

    // Timeline model: note lasts max(note_len,1) ticks from ON, next ON follows the OFF
    // after gap_len ticks (or the next cycle), the sequence ends one cycle after the last gap.
    task automatic model_play(input int c0, input int ls, input int nl, input int gl,
                              input int stop_c, input int rst_c, output int end_c);
        ev_t evs[$];
        int  t, off, done_c, nt, abort_c;
        int  win_t[8], win_off[8], win_freq[8];
        bit  win_rest[8];
        bit  aborted, by_reset;
        nt = (nl == 0) ? 1 : nl;
        t  = c0 + 1;
        done_c = 0;
        for (int s = 0; s <= ls; s++) begin
            off         = t + nt * TD;
            win_t[s]    = t;
            win_off[s]  = off;
            win_rest[s] = mdl_pat[s][3];
            win_freq[s] = int'(mdl_pat[s][2:0]);
            if (!win_rest[s]) begin
                evs.push_back('{EV_ON, t, win_freq[s], s});
                evs.push_back('{EV_OFF, off, win_freq[s], s});
            end
            if (s < ls) t      = (gl == 0) ? off + 1 : off + gl * TD;
            else        done_c = (gl == 0) ? off + 1 : off + gl * TD + 1;
        end
        evs.push_back('{EV_DONE, done_c, 0, 0});

        aborted  = 1'b0;
        by_reset = 1'b0;
        abort_c  = done_c;
        if (stop_c > c0 && stop_c < done_c) begin
            aborted = 1'b1;
            abort_c = stop_c;
        end
        if (rst_c > c0 && rst_c < done_c && rst_c < abort_c) begin
            aborted  = 1'b1;
            by_reset = 1'b1;
            abort_c  = rst_c;
        end
        for (int i = 0; i < evs.size(); i++)
            if (!aborted || evs[i].cyc <= abort_c) sb_q.push_back(evs[i]);
        if (aborted && !by_reset)
            for (int s = 0; s <= ls; s++)
                if (!win_rest[s] && abort_c >= win_t[s] && abort_c < win_off[s])
                    sb_q.push_back('{EV_OFF, abort_c + 1, win_freq[s], s});
        end_c = aborted ? abort_c + 1 : done_c;
        if (rst_c >= 0)
            for (int i = 0; i < 8; i++) mdl_pat[i] = '0;
    endtask

    task automatic play(input int ls, input int nl, input int gl, input int stop_off,
                        input int rst_off, input bit mid_wr, input bit busy_start);
        int         c0, end_c, stop_c, rst_c, last_c, wr_s;
        logic [3:0] wr_v;
        last_step = 3'(ls);
        note_len  = 8'(nl);
        gap_len   = 8'(gl);
        next_cycle();
        c0     = cyc;
        stop_c = (stop_off > 0) ? c0 + stop_off : -1;
        rst_c  = (rst_off > 0) ? c0 + rst_off : -1;
        wr_s   = $urandom_range(7, 1);
        wr_v   = 4'($urandom);
        if (mid_wr) mdl_pat[wr_s] = wr_v;
        model_play(c0, ls, nl, gl, stop_c, rst_c, end_c);
        busy_lo = c0 + 1;
        busy_hi = end_c - 1;
        last_c  = end_c + 2;
        if (rst_c + 2 > last_c) last_c = rst_c + 2;
        while (cyc <= last_c) begin
            start   = (cyc == c0) || (busy_start && cyc == c0 + 3 && c0 + 3 <= end_c - 1);
            stop    = (cyc == stop_c);
            reset   = (cyc == rst_c);
            wr_en   = mid_wr && (cyc == c0 + 2);
            wr_addr = 3'(wr_s);
            wr_data = wr_v;
            if (rst_c >= 0 && cyc == rst_c + 1) begin
                check("rst_freq", freq_select, 0);
                check("rst_note_on", note_on, 0);
                check("rst_note_off", note_off, 0);
                check("rst_busy", busy, 0);
                check("rst_step", step_idx, 0);
                check("rst_done", done, 0);
            end
            next_cycle();
        end
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        wr_en = 1'b0;
        check("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ls, nl, gl, so, ro;
        reset = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; last_step = '0; note_len = '0; gap_len = '0;
        for (int i = 0; i < 8; i++) mdl_pat[i] = '0;
        repeat (3) next_cycle();
        check("reset_freq", freq_select, 0);
        check("reset_note_on", note_on, 0);
        check("reset_note_off", note_off, 0);
        check("reset_busy", busy, 0);
        check("reset_step", step_idx, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        next_cycle();

        // Three-note pattern, then the same with a rest in the middle, then aborted at +5.
        mdl_pat[0] = 4'd1; mdl_pat[1] = 4'd2; mdl_pat[2] = 4'd3;
        write_all();
        play(2, 2, 1, 0, 0, 1'b0, 1'b0);
        mdl_pat[1] = 4'h8;
        write_all();
        play(2, 2, 1, 0, 0, 1'b0, 1'b0);
        mdl_pat[1] = 4'd2;
        write_all();
        play(2, 2, 1, 5, 0, 1'b0, 1'b0);

        // Shortest sequence, then start and stop together in idle.
        play(0, 0, 0, 0, 0, 1'b0, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        next_cycle();
        start = 1'b0;
        stop  = 1'b0;
        repeat (20) next_cycle();

        // Reset mid-note, then replay to see the cleared pattern.
        play(3, 2, 1, 0, 6, 1'b0, 1'b1);
        play(1, 1, 0, 0, 0, 1'b0, 1'b0);

        repeat (24) begin
            for (int i = 0; i < 8; i++)
                mdl_pat[i] = {($urandom_range(3) == 0), 3'($urandom)};
            write_all();
            ls = $urandom_range(7);
            nl = $urandom_range(3);
            gl = $urandom_range(3);
            so = ($urandom_range(2) == 0) ? $urandom_range(40, 1) : 0;
            ro = (so == 0 && $urandom_range(5) == 0) ? $urandom_range(30, 4) : 0;
            play(ls, nl, gl, so, ro, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
